// File: rtl/led_pattern_sequencer.sv
// Four-switch debounced command front end driving a mode FSM that owns the
// LED pattern datapath: off, chase, bounce, blink or manual per-LED toggle.
module led_pattern_sequencer #(
    parameter int DEBOUNCE_LIMIT = 250000,
    parameter int STEP_TICKS     = 6250000
) (
    input  logic       i_Clk,
    input  logic       i_Rst,
    input  logic       i_Switch_1,
    input  logic       i_Switch_2,
    input  logic       i_Switch_3,
    input  logic       i_Switch_4,
    output logic       o_LED_1,
    output logic       o_LED_2,
    output logic       o_LED_3,
    output logic       o_LED_4,
    output logic [2:0] o_Mode
);

    localparam int DB_W = $clog2(DEBOUNCE_LIMIT + 1);
    localparam int TM_W = $clog2(STEP_TICKS);
    localparam logic [DB_W-1:0] DB_LAST   = DB_W'(DEBOUNCE_LIMIT - 1);
    localparam logic [TM_W-1:0] TC_NORMAL = TM_W'(STEP_TICKS - 1);
    localparam logic [TM_W-1:0] TC_FAST   = TM_W'(STEP_TICKS / 2 - 1);

    typedef enum logic [2:0] {
        MODE_OFF    = 3'd0,
        MODE_CHASE  = 3'd1,
        MODE_BOUNCE = 3'd2,
        MODE_BLINK  = 3'd3,
        MODE_MANUAL = 3'd4
    } mode_t;

    logic [3:0] raw;
    logic [3:0] deb;
    logic [3:0] release_pulse;

    assign raw = {i_Switch_4, i_Switch_3, i_Switch_2, i_Switch_1};

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_debounce
            logic [DB_W-1:0] count_reg;
            logic            deb_reg;
            logic            deb_dly_reg;

            always_ff @(posedge i_Clk) begin
                if (i_Rst) begin
                    count_reg   <= '0;
                    deb_reg     <= 1'b0;
                    deb_dly_reg <= 1'b0;
                end else begin
                    deb_dly_reg <= deb_reg;
                    if (raw[gi] == deb_reg) begin
                        count_reg <= '0;
                    end else if (count_reg == DB_LAST) begin
                        deb_reg   <= raw[gi];
                        count_reg <= '0;
                    end else begin
                        count_reg <= count_reg + 1'b1;
                    end
                end
            end

            assign deb[gi]           = deb_reg;
            assign release_pulse[gi] = deb_dly_reg & ~deb_reg;
        end
    endgenerate

    // A mode change swallows every other command that lands in the same cycle.
    logic cmd_mode, cmd_pause, cmd_s3, cmd_s4;
    assign cmd_mode  = release_pulse[0];
    assign cmd_pause = release_pulse[1] & ~release_pulse[0];
    assign cmd_s3    = release_pulse[2] & ~release_pulse[0];
    assign cmd_s4    = release_pulse[3] & ~release_pulse[0];

    mode_t           mode_reg, mode_next;
    logic [3:0]      led_reg, led_next;
    logic [3:0]      manual_reg, manual_next;
    logic [1:0]      cursor_reg, cursor_next;
    logic [TM_W-1:0] timer_reg, timer_next;
    logic            paused_reg, paused_next;
    logic            fast_reg, fast_next;
    logic            dir_up_reg, dir_up_next;

    logic            running;
    logic            tick;
    logic [TM_W-1:0] terminal;

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            mode_reg   <= MODE_OFF;
            led_reg    <= 4'b0000;
            manual_reg <= 4'b0000;
            cursor_reg <= 2'd0;
            timer_reg  <= '0;
            paused_reg <= 1'b0;
            fast_reg   <= 1'b0;
            dir_up_reg <= 1'b1;
        end else begin
            mode_reg   <= mode_next;
            led_reg    <= led_next;
            manual_reg <= manual_next;
            cursor_reg <= cursor_next;
            timer_reg  <= timer_next;
            paused_reg <= paused_next;
            fast_reg   <= fast_next;
            dir_up_reg <= dir_up_next;
        end
    end

    always_comb begin
        mode_next = mode_reg;
        if (cmd_mode) begin
            case (mode_reg)
                MODE_OFF:    mode_next = MODE_CHASE;
                MODE_CHASE:  mode_next = MODE_BOUNCE;
                MODE_BOUNCE: mode_next = MODE_BLINK;
                MODE_BLINK:  mode_next = MODE_MANUAL;
                default:     mode_next = MODE_OFF;
            endcase
        end
    end

    assign running  = ((mode_reg == MODE_CHASE) || (mode_reg == MODE_BOUNCE) ||
                       (mode_reg == MODE_BLINK)) && !paused_reg;
    assign terminal = fast_reg ? TC_FAST : TC_NORMAL;
    assign tick     = running && (timer_reg == terminal);

    always_comb begin
        led_next    = led_reg;
        manual_next = manual_reg;
        cursor_next = cursor_reg;
        timer_next  = timer_reg;
        paused_next = paused_reg;
        fast_next   = fast_reg;
        dir_up_next = dir_up_reg;

        if (cmd_mode) begin
            timer_next  = '0;
            paused_next = 1'b0;
            dir_up_next = 1'b1;
            case (mode_next)
                MODE_CHASE:  led_next = 4'b0001;
                MODE_BOUNCE: led_next = 4'b0001;
                MODE_BLINK:  led_next = 4'b1111;
                MODE_MANUAL: led_next = manual_reg;
                default:     led_next = 4'b0000;
            endcase
        end else begin
            if (cmd_pause) paused_next = ~paused_reg;
            if (running) timer_next = tick ? '0 : timer_reg + 1'b1;

            if (tick) begin
                case (mode_reg)
                    MODE_CHASE: led_next = {led_reg[2:0], led_reg[3]};
                    MODE_BOUNCE: begin
                        // Reverse at either end so each end pattern shows once per sweep.
                        if (dir_up_reg) begin
                            if (led_reg[3]) begin
                                led_next    = 4'b0100;
                                dir_up_next = 1'b0;
                            end else begin
                                led_next = led_reg << 1;
                            end
                        end else begin
                            if (led_reg[0]) begin
                                led_next    = 4'b0010;
                                dir_up_next = 1'b1;
                            end else begin
                                led_next = led_reg >> 1;
                            end
                        end
                    end
                    MODE_BLINK: led_next = ~led_reg;
                    default: ;
                endcase
            end

            if (mode_reg == MODE_MANUAL) begin
                if (cmd_s4) manual_next = manual_reg ^ (4'b0001 << cursor_reg);
                if (cmd_s3) cursor_next = cursor_reg + 2'd1;
                led_next = manual_next;
            end else if (cmd_s3) begin
                fast_next  = ~fast_reg;
                timer_next = '0;
            end
        end
    end

    always_comb begin
        o_LED_1 = led_reg[0];
        o_LED_2 = led_reg[1];
        o_LED_3 = led_reg[2];
        o_LED_4 = led_reg[3];
        o_Mode  = mode_reg;
    end

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Directed bench for led_pattern_sequencer with short debounce and step times;
// expected LED/mode values are worked out by hand from the release timing.
module tb_led_pattern_sequencer;

    logic       clk;
    logic       rst;
    logic [3:0] sw;
    logic       led_1, led_2, led_3, led_4;
    logic [2:0] mode;
    logic [3:0] leds;

    int checks;
    int errors;

    led_pattern_sequencer #(
        .DEBOUNCE_LIMIT(4),
        .STEP_TICKS    (8)
    ) dut (
        .i_Clk     (clk),
        .i_Rst     (rst),
        .i_Switch_1(sw[0]),
        .i_Switch_2(sw[1]),
        .i_Switch_3(sw[2]),
        .i_Switch_4(sw[3]),
        .o_LED_1   (led_1),
        .o_LED_2   (led_2),
        .o_LED_3   (led_3),
        .o_LED_4   (led_4),
        .o_Mode    (mode)
    );

    assign leds = {led_4, led_3, led_2, led_1};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end else begin
            $display("ok   %s got=%0h", tag, got);
        end
    endtask

    // Release lands 5 edges after the switch drops: 4 debounce cycles + pulse cycle.
    task automatic press_release(input logic [3:0] mask, input int hold);
        sw = mask;
        step(hold);
        sw = 4'b0000;
        step(5);
    endtask

    logic [3:0] chase_exp  [3] = '{4'b0100, 4'b1000, 4'b0001};
    logic [3:0] bounce_exp [7] = '{4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0010};

    initial begin
        checks = 0;
        errors = 0;
        sw     = 4'b0000;
        rst    = 1'b1;
        step(2);
        rst = 1'b0;
        step(1);
        check_eq("reset_mode", 8'(mode), 8'd0);
        check_eq("reset_led", 8'(leds), 8'h0);

        // 3-cycle glitch is one short of the debounce limit
        sw = 4'b0001;
        step(3);
        sw = 4'b0000;
        step(8);
        check_eq("glitch_mode", 8'(mode), 8'd0);
        check_eq("glitch_led", 8'(leds), 8'h0);

        press_release(4'b0001, 10);
        check_eq("chase_mode", 8'(mode), 8'd1);
        check_eq("chase_entry", 8'(leds), 8'h1);
        step(7);
        check_eq("chase_hold7", 8'(leds), 8'h1);
        step(1);
        check_eq("chase_step1", 8'(leds), 8'h2);
        for (int i = 0; i < 3; i++) begin
            step(8);
            check_eq("chase_step", 8'(leds), 8'(chase_exp[i]));
        end

        // Speed toggle: a tick at +8 into the press window leaves 0010 showing
        press_release(4'b0100, 6);
        check_eq("fast_entry", 8'(leds), 8'h2);
        step(3);
        check_eq("fast_hold3", 8'(leds), 8'h2);
        step(1);
        check_eq("fast_step1", 8'(leds), 8'h4);
        step(4);
        check_eq("fast_step2", 8'(leds), 8'h8);

        // Bounce at retained fast speed: one step per 4 cycles
        press_release(4'b0001, 6);
        check_eq("bounce_mode", 8'(mode), 8'd2);
        check_eq("bounce_entry", 8'(leds), 8'h1);
        for (int i = 0; i < 7; i++) begin
            step(4);
            check_eq("bounce_step", 8'(leds), 8'(bounce_exp[i]));
        end

        press_release(4'b0001, 6);
        check_eq("blink_mode", 8'(mode), 8'd3);
        check_eq("blink_entry", 8'(leds), 8'hf);
        // Ticks at +4,+8,+12 then pause lands at +13 with timer frozen at 1
        press_release(4'b0010, 8);
        check_eq("pause_entry", 8'(leds), 8'h0);
        for (int i = 0; i < 100; i++) begin
            step(1);
            check_eq("pause_frozen", 8'(leds), 8'h0);
        end
        press_release(4'b0010, 6);
        check_eq("resume_entry", 8'(leds), 8'h0);
        step(2);
        check_eq("resume_hold2", 8'(leds), 8'h0);
        step(1);
        check_eq("resume_toggle", 8'(leds), 8'hf);

        press_release(4'b0001, 6);
        check_eq("manual_mode", 8'(mode), 8'd4);
        check_eq("manual_entry", 8'(leds), 8'h0);
        press_release(4'b1000, 6);
        check_eq("manual_s4a", 8'(leds), 8'h1);
        press_release(4'b0100, 6);
        check_eq("manual_s3a", 8'(leds), 8'h1);
        press_release(4'b0100, 6);
        check_eq("manual_s3b", 8'(leds), 8'h1);
        press_release(4'b1000, 6);
        check_eq("manual_s4b", 8'(leds), 8'h5);

        // Same-cycle S1+S4: only the mode change takes effect
        press_release(4'b1001, 6);
        check_eq("prio_mode", 8'(mode), 8'd0);
        check_eq("prio_led", 8'(leds), 8'h0);
        for (int i = 1; i <= 3; i++) begin
            press_release(4'b0001, 6);
            check_eq("prio_walk", 8'(mode), 8'(i));
        end
        press_release(4'b0001, 6);
        check_eq("prio_manual_mode", 8'(mode), 8'd4);
        check_eq("prio_manual_led", 8'(leds), 8'h5);

        press_release(4'b0001, 6);
        check_eq("wrap_off", 8'(mode), 8'd0);
        press_release(4'b0001, 6);
        check_eq("rst_pre_mode", 8'(mode), 8'd1);
        check_eq("rst_pre_led", 8'(leds), 8'h1);
        // Debounced press, then reset two cycles into the release debounce
        sw = 4'b0001;
        step(6);
        sw = 4'b0000;
        step(2);
        rst = 1'b1;
        step(1);
        check_eq("rst_mode", 8'(mode), 8'd0);
        check_eq("rst_led", 8'(leds), 8'h0);
        rst = 1'b0;
        step(10);
        check_eq("rst_nopulse_mode", 8'(mode), 8'd0);
        check_eq("rst_nopulse_led", 8'(leds), 8'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
